// File: rtl/axi4_lite_rif_bridge.sv
// AXI4-Lite slave bridging to NUM_RIF register-file ports with per-direction
// req/ack handshake, wait states, timeout and AXI error responses.
module axi4_lite_rif_bridge #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int RIF_ADDR_WIDTH = 10,
  parameter int NUM_RIF        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int EN_SEC_MODE    = 0,
  parameter int NO_SEC_FAIL    = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ID_WIDTH-1:0]       awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [AXI_ID_WIDTH-1:0]       bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [AXI_ID_WIDTH-1:0]       arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [AXI_ID_WIDTH-1:0]       rid,
  output logic [AXI_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [NUM_RIF-1:0]            rif_wr_req,
  output logic [RIF_ADDR_WIDTH-1:0]     rif_waddr,
  output logic [AXI_DATA_WIDTH-1:0]     rif_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   rif_wstrb,
  input  logic [NUM_RIF-1:0]            rif_wack,
  input  logic [NUM_RIF-1:0]            rif_werr,
  output logic [NUM_RIF-1:0]            rif_rd_req,
  output logic [RIF_ADDR_WIDTH-1:0]     rif_raddr,
  input  logic [NUM_RIF-1:0]            rif_rack,
  input  logic [NUM_RIF-1:0]            rif_rerr,
  input  logic [NUM_RIF*AXI_DATA_WIDTH-1:0] rif_rdata,
  output logic [3:0]                    dbg_state
);
  // All AXI channels follow valid/ready: a beat transfers on the rising edge
  // where both are high; the sender holds payload stable while valid && !ready.
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int IW = AXI_ADDR_WIDTH - RIF_ADDR_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LAST_V = TO_LAST[TW-1:0];
  localparam logic [IW:0] NUM_RIF_V = NUM_RIF[IW:0];
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] SEC_RESP = (NO_SEC_FAIL != 0) ? RESP_OKAY : RESP_SLVERR;

  if (NUM_RIF < 1 || NUM_RIF > (1 << IW)) begin : g_bad_num_rif
    $error("NUM_RIF does not fit the port index field");
  end

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                      aw_full, w_full, ar_full;
  logic [AXI_ID_WIDTH-1:0]   aw_id, ar_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic                      aw_prot1, ar_prot1;
  logic [DW-1:0]             w_data, rd_mux, r_data_nxt;
  logic [SW-1:0]             w_strb;
  logic [TW-1:0]             w_timer, r_timer;
  logic                      w_release, w_load, r_release, r_load;
  logic [1:0]                w_resp_nxt, r_resp_nxt;

  logic unused_prot;
  assign unused_prot = ^{awprot[2], awprot[0], arprot[2], arprot[0]};

  // Holding registers; they free up on leaving the decision/REQ state so the
  // next transaction can be accepted while the response is still pending.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full <= 1'b0; aw_id <= '0; aw_addr <= '0; aw_prot1 <= 1'b0;
      w_full  <= 1'b0; w_data <= '0; w_strb <= '0;
      ar_full <= 1'b0; ar_id <= '0; ar_addr <= '0; ar_prot1 <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_full <= 1'b1; aw_id <= awid; aw_addr <= awaddr; aw_prot1 <= awprot[1];
      end else if (w_release) begin
        aw_full <= 1'b0;
      end
      if (wvalid && wready) begin
        w_full <= 1'b1; w_data <= wdata; w_strb <= wstrb;
      end else if (w_release) begin
        w_full <= 1'b0;
      end
      if (arvalid && arready) begin
        ar_full <= 1'b1; ar_id <= arid; ar_addr <= araddr; ar_prot1 <= arprot[1];
      end else if (r_release) begin
        ar_full <= 1'b0;
      end
    end
  end

  assign awready   = !aw_full;
  assign wready    = !w_full;
  assign arready   = !ar_full;
  assign rif_waddr = aw_addr[RIF_ADDR_WIDTH-1:0];
  assign rif_wdata = w_data;
  assign rif_wstrb = w_strb;
  assign rif_raddr = ar_addr[RIF_ADDR_WIDTH-1:0];
  assign dbg_state = {r_state, w_state};

  logic [IW-1:0]      aw_idx, ar_idx;
  logic [NUM_RIF-1:0] aw_sel, ar_sel;
  logic               aw_dec_err, ar_dec_err, aw_blk, ar_blk;
  logic               w_ack, w_err, r_ack, r_err, w_timeout, r_timeout;

  assign aw_idx     = aw_addr[AXI_ADDR_WIDTH-1:RIF_ADDR_WIDTH];
  assign ar_idx     = ar_addr[AXI_ADDR_WIDTH-1:RIF_ADDR_WIDTH];
  assign aw_dec_err = {1'b0, aw_idx} >= NUM_RIF_V;
  assign ar_dec_err = {1'b0, ar_idx} >= NUM_RIF_V;
  assign aw_sel     = NUM_RIF'(1) << aw_idx;
  assign ar_sel     = NUM_RIF'(1) << ar_idx;
  assign aw_blk     = (EN_SEC_MODE != 0) && !aw_prot1;
  assign ar_blk     = (EN_SEC_MODE != 0) && !ar_prot1;
  assign w_ack      = |(rif_wack & aw_sel);
  assign w_err      = |(rif_werr & aw_sel);
  assign r_ack      = |(rif_rack & ar_sel);
  assign r_err      = |(rif_rerr & ar_sel);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_timer == TO_LAST_V);
  assign r_timeout  = (TIMEOUT_CYCLES != 0) && (r_timer == TO_LAST_V);

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_RIF; p++)
      if (ar_sel[p]) rd_mux = rif_rdata[p*DW +: DW];
  end

  // Write FSM: state register, next-state, outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state; w_release = 1'b0; w_load = 1'b0; w_resp_nxt = RESP_OKAY;
    case (w_state)
      W_IDLE: if (aw_full && w_full) begin
        if (aw_dec_err) begin
          w_next = W_RESP; w_release = 1'b1; w_load = 1'b1; w_resp_nxt = RESP_DECERR;
        end else if (aw_blk) begin
          w_next = W_RESP; w_release = 1'b1; w_load = 1'b1; w_resp_nxt = SEC_RESP;
        end else begin
          w_next = W_REQ;
        end
      end
      W_REQ: if (w_ack || w_timeout) begin
        w_next = W_RESP; w_release = 1'b1; w_load = 1'b1;
        w_resp_nxt = (!w_ack || w_err) ? RESP_SLVERR : RESP_OKAY;
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    bvalid     = (w_state == W_RESP);
    rif_wr_req = (w_state == W_REQ) ? aw_sel : '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bid <= '0; bresp <= RESP_OKAY; w_timer <= '0;
    end else begin
      w_timer <= (w_state == W_REQ) ? w_timer + 1'b1 : '0;
      if (w_load) begin
        bid <= aw_id; bresp <= w_resp_nxt;
      end
    end
  end

  // Read FSM: same structure; data is zero unless the RIF actually acked.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state; r_release = 1'b0; r_load = 1'b0; r_resp_nxt = RESP_OKAY;
    r_data_nxt = '0;
    case (r_state)
      R_IDLE: if (ar_full) begin
        if (ar_dec_err) begin
          r_next = R_RESP; r_release = 1'b1; r_load = 1'b1; r_resp_nxt = RESP_DECERR;
        end else if (ar_blk) begin
          r_next = R_RESP; r_release = 1'b1; r_load = 1'b1; r_resp_nxt = SEC_RESP;
        end else begin
          r_next = R_REQ;
        end
      end
      R_REQ: if (r_ack || r_timeout) begin
        r_next = R_RESP; r_release = 1'b1; r_load = 1'b1;
        r_resp_nxt = (!r_ack || r_err) ? RESP_SLVERR : RESP_OKAY;
        if (r_ack) r_data_nxt = rd_mux;
      end
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rvalid     = (r_state == R_RESP);
    rif_rd_req = (r_state == R_REQ) ? ar_sel : '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid <= '0; rresp <= RESP_OKAY; rdata <= '0; r_timer <= '0;
    end else begin
      r_timer <= (r_state == R_REQ) ? r_timer + 1'b1 : '0;
      if (r_load) begin
        rid <= ar_id; rresp <= r_resp_nxt; rdata <= r_data_nxt;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_rif_bridge.sv
// Directed bench for axi4_lite_rif_bridge: main instance with 3 ports and
// security enabled, second instance with blocked accesses answered OKAY.
module tb_axi4_lite_rif_bridge;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [0:0] awid, bid, arid, rid;
  logic [11:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, rif_wdata;
  logic [3:0] wstrb, rif_wstrb, dbg_state;
  logic [1:0] bresp, rresp;
  logic [2:0] rif_wr_req, rif_wack, rif_werr, rif_rd_req, rif_rack, rif_rerr;
  logic [9:0] rif_waddr, rif_raddr;
  logic [95:0] rif_rdata;

  logic [0:0] n_awid, n_bid, n_arid, n_rid;
  logic [11:0] n_awaddr, n_araddr;
  logic [2:0] n_awprot, n_arprot;
  logic n_awvalid, n_awready, n_wvalid, n_wready, n_bvalid, n_bready;
  logic n_arvalid, n_arready, n_rvalid, n_rready;
  logic [31:0] n_wdata, n_rdata, n_rif_wdata;
  logic [3:0] n_wstrb, n_rif_wstrb, n_dbg_state;
  logic [1:0] n_bresp, n_rresp;
  logic [1:0] n_rif_wr_req, n_rif_wack, n_rif_werr, n_rif_rd_req, n_rif_rack, n_rif_rerr;
  logic [9:0] n_rif_waddr, n_rif_raddr;
  logic [63:0] n_rif_rdata;

  axi4_lite_rif_bridge #(.AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32),
    .RIF_ADDR_WIDTH(10), .NUM_RIF(3), .TIMEOUT_CYCLES(16), .EN_SEC_MODE(1), .NO_SEC_FAIL(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rif_wr_req(rif_wr_req), .rif_waddr(rif_waddr), .rif_wdata(rif_wdata), .rif_wstrb(rif_wstrb),
    .rif_wack(rif_wack), .rif_werr(rif_werr), .rif_rd_req(rif_rd_req), .rif_raddr(rif_raddr),
    .rif_rack(rif_rack), .rif_rerr(rif_rerr), .rif_rdata(rif_rdata), .dbg_state(dbg_state));

  axi4_lite_rif_bridge #(.AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32),
    .RIF_ADDR_WIDTH(10), .NUM_RIF(2), .TIMEOUT_CYCLES(16), .EN_SEC_MODE(1), .NO_SEC_FAIL(1)) dut_nsf (
    .aclk(aclk), .aresetn(aresetn),
    .awid(n_awid), .awaddr(n_awaddr), .awprot(n_awprot), .awvalid(n_awvalid), .awready(n_awready),
    .wdata(n_wdata), .wstrb(n_wstrb), .wvalid(n_wvalid), .wready(n_wready),
    .bid(n_bid), .bresp(n_bresp), .bvalid(n_bvalid), .bready(n_bready),
    .arid(n_arid), .araddr(n_araddr), .arprot(n_arprot), .arvalid(n_arvalid), .arready(n_arready),
    .rid(n_rid), .rdata(n_rdata), .rresp(n_rresp), .rvalid(n_rvalid), .rready(n_rready),
    .rif_wr_req(n_rif_wr_req), .rif_waddr(n_rif_waddr), .rif_wdata(n_rif_wdata), .rif_wstrb(n_rif_wstrb),
    .rif_wack(n_rif_wack), .rif_werr(n_rif_werr), .rif_rd_req(n_rif_rd_req), .rif_raddr(n_rif_raddr),
    .rif_rack(n_rif_rack), .rif_rerr(n_rif_rerr), .rif_rdata(n_rif_rdata), .dbg_state(n_dbg_state));

  int total = 0;
  int bad = 0;
  logic [2:0]  exp_b_q[$];   // {bid, bresp}
  logic [34:0] exp_r_q[$];   // {rid, rresp, rdata}

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic bv, input logic id, input logic [1:0] resp);
    logic [2:0] e;
    check({tag, ".bvalid"}, bv, 1);
    if (exp_b_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: observed=B response expected=empty scoreboard entry", tag);
    end else begin
      e = exp_b_q.pop_front();
      check({tag, ".bid"}, id, e[2]);
      check({tag, ".bresp"}, resp, e[1:0]);
    end
  endtask

  task automatic check_r(input string tag, input logic rv, input logic id, input logic [1:0] resp,
                         input logic [31:0] data);
    logic [34:0] e;
    check({tag, ".rvalid"}, rv, 1);
    if (exp_r_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: observed=R response expected=empty scoreboard entry", tag);
    end else begin
      e = exp_r_q.pop_front();
      check({tag, ".rid"}, id, e[34]);
      check({tag, ".rresp"}, resp, e[33:32]);
      check({tag, ".rdata"}, data, e[31:0]);
    end
  endtask

  task automatic send_aw(input logic id, input logic [11:0] addr, input logic [2:0] prot);
    awid = id; awaddr = addr; awprot = prot; awvalid = 1'b1;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    wdata = data; wstrb = strb; wvalid = 1'b1;
  endtask

  task automatic send_ar(input logic id, input logic [11:0] addr, input logic [2:0] prot);
    arid = id; araddr = addr; arprot = prot; arvalid = 1'b1;
  endtask

  task automatic accept_b();
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic accept_r();
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d0, d2, d3;
    int cnt;
    awid = '0; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; arid = '0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    rif_wack = '0; rif_werr = '0; rif_rack = '0; rif_rerr = '0; rif_rdata = '0;
    n_awid = '0; n_awaddr = '0; n_awprot = '0; n_awvalid = 0; n_wdata = '0; n_wstrb = '0;
    n_wvalid = 0; n_bready = 0; n_arid = '0; n_araddr = '0; n_arprot = '0; n_arvalid = 0;
    n_rready = 0; n_rif_wack = '0; n_rif_werr = '0; n_rif_rack = '0; n_rif_rerr = '0;
    n_rif_rdata = '0;

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst.awready", awready, 1); check("rst.wready", wready, 1);
    check("rst.arready", arready, 1); check("rst.bvalid", bvalid, 0);
    check("rst.rvalid", rvalid, 0); check("rst.wr_req", rif_wr_req, 0);
    check("rst.rd_req", rif_rd_req, 0); check("rst.bresp", bresp, 0);
    check("rst.rresp", rresp, 0); check("rst.bid", bid, 0); check("rst.rid", rid, 0);
    check("rst.rdata", rdata, 0); check("rst.waddr", rif_waddr, 0);
    check("rst.wdata", rif_wdata, 0); check("rst.wstrb", rif_wstrb, 0);
    check("rst.raddr", rif_raddr, 0); check("rst.state", dbg_state, 0);
    check("rst.n_awready", n_awready, 1);
    aresetn = 1'b1;
    tick();

    // Basic write: AW and W together, ack on first REQ cycle
    send_aw(1'b1, 12'h404, 3'b010); send_w(32'hDEADBEEF, 4'hF);
    exp_b_q.push_back({1'b1, 2'b00});
    tick(); awvalid = 0; wvalid = 0;
    check("bw.awready_n1", awready, 0); check("bw.req_n1", rif_wr_req, 0);
    tick();
    check("bw.req", rif_wr_req, 3'b010); check("bw.waddr", rif_waddr, 10'h004);
    check("bw.wdata", rif_wdata, 32'hDEADBEEF); check("bw.wstrb", rif_wstrb, 4'hF);
    rif_wack = 3'b010; tick(); rif_wack = '0;
    check_b("bw", bvalid, bid, bresp);
    check("bw.req_off", rif_wr_req, 0);
    accept_b();
    check("bw.bdone", bvalid, 0);

    // Read with 5 wait states
    d0 = $urandom();
    rif_rdata = {32'hAAAA5555, 32'h0BAD0BAD, d0};
    send_ar(1'b0, 12'h008, 3'b010);
    exp_r_q.push_back({1'b0, 2'b00, d0});
    tick(); arvalid = 0; tick();
    check("rw.req", rif_rd_req, 3'b001); check("rw.raddr", rif_raddr, 10'h008);
    repeat (5) tick();
    check("rw.req_wait", rif_rd_req, 3'b001); check("rw.rvalid_wait", rvalid, 0);
    rif_rack = 3'b001; tick(); rif_rack = '0;
    rif_rdata[31:0] = ~d0;
    check_r("rw", rvalid, rid, rresp, rdata);
    accept_r();

    // Read timeout: request held 16 cycles, SLVERR with zero data
    send_ar(1'b0, 12'h008, 3'b010);
    exp_r_q.push_back({1'b0, 2'b10, 32'h0});
    tick(); arvalid = 0; tick();
    cnt = 0;
    while (rif_rd_req == 3'b001 && cnt < 40) begin
      cnt++; tick();
    end
    check("to.req_cycles", cnt, 16);
    check_r("to", rvalid, rid, rresp, rdata);
    rif_rack = 3'b001; tick(); rif_rack = '0;
    check("to.late_ack_rdata", rdata, 0); check("to.late_ack_rresp", rresp, 2'b10);
    accept_r(); tick();
    check("to.idle", rvalid, 0);

    // Decode error on index 3
    send_aw(1'b0, 12'hC00, 3'b010); send_w($urandom(), 4'h3);
    exp_b_q.push_back({1'b0, 2'b11});
    tick(); awvalid = 0; wvalid = 0;
    check("dec_w.bvalid_n1", bvalid, 0);
    tick();
    check_b("dec_w", bvalid, bid, bresp); check("dec_w.req", rif_wr_req, 0);
    accept_b();
    send_ar(1'b1, 12'hC04, 3'b010);
    exp_r_q.push_back({1'b1, 2'b11, 32'h0});
    tick(); arvalid = 0; tick();
    check_r("dec_r", rvalid, rid, rresp, rdata); check("dec_r.req", rif_rd_req, 0);
    accept_r();

    // Security: prot[1]=0 blocked with SLVERR
    send_aw(1'b1, 12'h010, 3'b000); send_w($urandom(), 4'hF);
    exp_b_q.push_back({1'b1, 2'b10});
    tick(); awvalid = 0; wvalid = 0; tick();
    check_b("sec_w", bvalid, bid, bresp); check("sec_w.req", rif_wr_req, 0);
    accept_b();
    send_ar(1'b0, 12'h014, 3'b101);
    exp_r_q.push_back({1'b0, 2'b10, 32'h0});
    tick(); arvalid = 0; tick();
    check_r("sec_r", rvalid, rid, rresp, rdata); check("sec_r.req", rif_rd_req, 0);
    accept_r();

    // W three cycles ahead of AW, then B backpressure with a second write queued
    send_w(32'h13579BDF, 4'hC);
    tick(); wvalid = 0;
    check("dcp.wready", wready, 0);
    repeat (3) tick();
    check("dcp.no_req", rif_wr_req, 0); check("dcp.w_idle", dbg_state[1:0], 0);
    send_aw(1'b1, 12'h000, 3'b010);
    exp_b_q.push_back({1'b1, 2'b10});
    tick(); awvalid = 0; tick();
    check("dcp.req", rif_wr_req, 3'b001); check("dcp.wdata", rif_wdata, 32'h13579BDF);
    check("dcp.wstrb", rif_wstrb, 4'hC);
    rif_wack = 3'b001; rif_werr = 3'b001; tick(); rif_wack = '0; rif_werr = '0;
    check_b("dcp", bvalid, bid, bresp);
    check("bp.awready", awready, 1); check("bp.wready", wready, 1);
    d2 = $urandom();
    send_aw(1'b0, 12'h408, 3'b010); send_w(d2, 4'hF);
    tick(); awvalid = 0; wvalid = 0;
    check("bp.aw_taken", awready, 0);
    repeat (3) begin
      check("bp.bvalid", bvalid, 1); check("bp.bid", bid, 1);
      check("bp.bresp", bresp, 2'b10); check("bp.no_req", rif_wr_req, 0);
      tick();
    end
    exp_b_q.push_back({1'b0, 2'b00});
    accept_b();
    check("bp.bdone", bvalid, 0); check("bp.req_n1", rif_wr_req, 0);
    tick();
    check("bp.req2", rif_wr_req, 3'b010); check("bp.waddr2", rif_waddr, 10'h008);
    check("bp.wdata2", rif_wdata, d2);
    rif_wack = 3'b010; tick(); rif_wack = '0;
    check_b("bp2", bvalid, bid, bresp);
    accept_b();

    // Concurrent read and write to port 0
    d3 = $urandom();
    rif_rdata[31:0] = d3;
    send_aw(1'b0, 12'h00C, 3'b010); send_w($urandom(), 4'hF); send_ar(1'b1, 12'h010, 3'b010);
    exp_b_q.push_back({1'b0, 2'b00});
    exp_r_q.push_back({1'b1, 2'b00, d3});
    tick(); awvalid = 0; wvalid = 0; arvalid = 0; tick();
    check("cc.wr_req", rif_wr_req, 3'b001); check("cc.rd_req", rif_rd_req, 3'b001);
    rif_wack = 3'b001; rif_rack = 3'b001; tick(); rif_wack = '0; rif_rack = '0;
    check_b("cc", bvalid, bid, bresp);
    check_r("cc", rvalid, rid, rresp, rdata);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    check("cc.bdone", bvalid, 0); check("cc.rdone", rvalid, 0);

    // Reset pulse during read REQ
    send_ar(1'b0, 12'h400, 3'b010);
    tick(); arvalid = 0; tick();
    check("rr.req", rif_rd_req, 3'b010);
    aresetn = 1'b0; #2;
    check("rr.req_async", rif_rd_req, 0); check("rr.arready_async", arready, 1);
    tick(); aresetn = 1'b1; tick();
    check("rr.rvalid", rvalid, 0); check("rr.arready", arready, 1); check("rr.state", dbg_state, 0);

    // NO_SEC_FAIL instance: blocked accesses answer OKAY, secure one is issued
    n_awid = 1'b1; n_awaddr = 12'h010; n_awprot = 3'b000; n_awvalid = 1;
    n_wdata = $urandom(); n_wstrb = 4'hF; n_wvalid = 1;
    exp_b_q.push_back({1'b1, 2'b00});
    tick(); n_awvalid = 0; n_wvalid = 0; tick();
    check_b("nsf_w", n_bvalid, n_bid, n_bresp); check("nsf_w.req", n_rif_wr_req, 0);
    n_bready = 1; tick(); n_bready = 0;
    n_rif_rdata = {$urandom(), $urandom()} | 64'h1;
    n_arid = 1'b1; n_araddr = 12'h004; n_arprot = 3'b000; n_arvalid = 1;
    exp_r_q.push_back({1'b1, 2'b00, 32'h0});
    tick(); n_arvalid = 0; tick();
    check_r("nsf_r", n_rvalid, n_rid, n_rresp, n_rdata); check("nsf_r.req", n_rif_rd_req, 0);
    n_rready = 1; tick(); n_rready = 0;
    n_awid = 1'b0; n_awaddr = 12'h404; n_awprot = 3'b010; n_awvalid = 1; n_wvalid = 1;
    exp_b_q.push_back({1'b0, 2'b00});
    tick(); n_awvalid = 0; n_wvalid = 0; tick();
    check("nsf_s.req", n_rif_wr_req, 2'b10);
    n_rif_wack = 2'b10; tick(); n_rif_wack = '0;
    check_b("nsf_s", n_bvalid, n_bid, n_bresp);
    n_bready = 1; tick(); n_bready = 0;

    check("sb.empty", exp_b_q.size() + exp_r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
